// File: rtl/mport_fifo.sv
// mport_fifo: multi-lane FIFO / free-list with NUM_PORTS get lanes and
// NUM_PORTS put lanes per cycle. Grants are handed out in lane order, so a
// lane can be refused while lower lanes are accepted.
//
// Ports
//   clk, rst          single clock, synchronous active-high reset
//   flush             empties the queue (pointers and count to zero, mem kept)
//   get_en/get_grant  per-lane pop request / accept
//   get_data          popped values, lane i at [i*WIDTH +: WIDTH], 0 when not granted
//   put_en/put_grant  per-lane push request / accept
//   put_data          push values, lane i at [i*WIDTH +: WIDTH]
//   count             registered occupancy
//   space             DEPTH - count
//   err_underflow     sticky: some get request was refused
//   err_overflow      sticky: some put request was refused
module mport_fifo #(
  parameter int DEPTH     = 64,
  parameter int WIDTH     = 6,
  parameter int NUM_PORTS = 3,
  parameter int INIT_FULL = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [NUM_PORTS-1:0]           get_en,
  output logic [NUM_PORTS-1:0]           get_grant,
  output logic [NUM_PORTS*WIDTH-1:0]     get_data,
  input  logic [NUM_PORTS-1:0]           put_en,
  input  logic [NUM_PORTS*WIDTH-1:0]     put_data,
  output logic [NUM_PORTS-1:0]           put_grant,
  output logic [$clog2(DEPTH):0]         count,
  output logic [$clog2(DEPTH):0]         space,
  output logic                           err_underflow,
  output logic                           err_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    head_q, head_d;
  logic [AW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             err_u_q, err_u_d;
  logic             err_o_q, err_o_d;

  // en_* count enabled requests on lower lanes (the acceptance test);
  // n_* count granted lanes so far (the rank used for addressing).
  int               en_get, en_put, n_get, n_put;
  logic             get_denied, put_denied;

  assign count         = count_q;
  assign space         = CW'(DEPTH) - count_q;
  assign err_underflow = err_u_q;
  assign err_overflow  = err_o_q;

  always_comb begin
    get_grant  = '0;
    put_grant  = '0;
    get_data   = '0;
    en_get     = 0;
    en_put     = 0;
    n_get      = 0;
    n_put      = 0;
    get_denied = 1'b0;
    put_denied = 1'b0;
    mem_d      = mem_q;

    if (!rst && !flush) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (get_en[i]) begin
          if (en_get < 32'(count_q)) begin
            get_grant[i]               = 1'b1;
            get_data[i*WIDTH +: WIDTH] = mem_q[head_q + AW'(n_get)];
            n_get                      = n_get + 1;
          end else begin
            get_denied = 1'b1;
          end
          en_get = en_get + 1;
        end
        // Space is judged against start-of-cycle occupancy; slots freed by
        // this cycle's gets only become usable next cycle.
        if (put_en[i]) begin
          if (en_put < 32'(space)) begin
            put_grant[i]                  = 1'b1;
            mem_d[tail_q + AW'(n_put)]    = put_data[i*WIDTH +: WIDTH];
            n_put                         = n_put + 1;
          end else begin
            put_denied = 1'b1;
          end
          en_put = en_put + 1;
        end
      end
    end

    head_d  = head_q + AW'(n_get);
    tail_d  = tail_q + AW'(n_put);
    count_d = count_q + CW'(n_put) - CW'(n_get);
    err_u_d = err_u_q | get_denied;
    err_o_d = err_o_q | put_denied;

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      err_u_q <= 1'b0;
      err_o_q <= 1'b0;
      if (INIT_FULL != 0) begin
        count_q <= CW'(DEPTH);
        for (int i = 0; i < DEPTH; i++) mem_q[i] <= WIDTH'(i);
      end else begin
        count_q <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_u_q <= err_u_d;
      err_o_q <= err_o_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: tb/tb_mport_fifo.sv
module tb_mport_fifo;

  localparam int DEPTH = 8;
  localparam int WIDTH = 4;
  localparam int NP    = 3;

  logic          clk = 1'b0;
  logic          rst, flush;
  logic [NP-1:0] get_en, get_grant, put_en, put_grant;
  logic [NP*WIDTH-1:0] get_data, put_data;
  logic [3:0]    count, space;
  logic          err_underflow, err_overflow;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mport_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .NUM_PORTS(NP), .INIT_FULL(1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .get_en(get_en), .get_grant(get_grant), .get_data(get_data),
    .put_en(put_en), .put_data(put_data), .put_grant(put_grant),
    .count(count), .space(space),
    .err_underflow(err_underflow), .err_overflow(err_overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          fl;
    logic [2:0]    ge;
    logic [2:0]    pe;
    logic [11:0]   pd;
    logic [2:0]    gg;
    logic [2:0]    pg;
    logic [11:0]   gd;
    logic [3:0]    cnt;
    logic          eu;
    logic          eo;
  } vec_t;

  vec_t tv [17];

  // Reference model: queue contents in pop order.
  int            q[$];
  logic          m_eu, m_eo;

  initial begin
    // Directed scenario, DEPTH=8; count/err columns are the values seen
    // before the clock edge that applies the vector.
    tv[0]  = '{1'b0, 3'b111, 3'b000, 12'h000, 3'b111, 3'b000, {4'd2, 4'd1, 4'd0},    4'd8, 1'b0, 1'b0};
    tv[1]  = '{1'b0, 3'b101, 3'b000, 12'h000, 3'b101, 3'b000, {4'd4, 4'd0, 4'd3},    4'd5, 1'b0, 1'b0};
    tv[2]  = '{1'b0, 3'b001, 3'b000, 12'h000, 3'b001, 3'b000, {4'd0, 4'd0, 4'd5},    4'd3, 1'b0, 1'b0};
    tv[3]  = '{1'b0, 3'b111, 3'b000, 12'h000, 3'b011, 3'b000, {4'd0, 4'd7, 4'd6},    4'd2, 1'b0, 1'b0};
    tv[4]  = '{1'b0, 3'b000, 3'b111, {4'd12, 4'd11, 4'd10}, 3'b000, 3'b111, 12'h000, 4'd0, 1'b1, 1'b0};
    tv[5]  = '{1'b0, 3'b000, 3'b111, {4'd15, 4'd14, 4'd13}, 3'b000, 3'b111, 12'h000, 4'd3, 1'b1, 1'b0};
    tv[6]  = '{1'b0, 3'b000, 3'b011, {4'd0, 4'd2, 4'd1},    3'b000, 3'b011, 12'h000, 4'd6, 1'b1, 1'b0};
    tv[7]  = '{1'b0, 3'b111, 3'b111, {4'd9, 4'd8, 4'd7},    3'b111, 3'b000, {4'd12, 4'd11, 4'd10}, 4'd8, 1'b1, 1'b0};
    tv[8]  = '{1'b0, 3'b000, 3'b111, {4'd5, 4'd4, 4'd3},    3'b000, 3'b111, 12'h000, 4'd5, 1'b1, 1'b1};
    tv[9]  = '{1'b0, 3'b111, 3'b000, 12'h000, 3'b111, 3'b000, {4'd15, 4'd14, 4'd13}, 4'd8, 1'b1, 1'b1};
    tv[10] = '{1'b0, 3'b000, 3'b111, {4'd8, 4'd7, 4'd6},    3'b000, 3'b111, 12'h000, 4'd5, 1'b1, 1'b1};
    tv[11] = '{1'b0, 3'b111, 3'b000, 12'h000, 3'b111, 3'b000, {4'd3, 4'd2, 4'd1},    4'd8, 1'b1, 1'b1};
    tv[12] = '{1'b0, 3'b001, 3'b000, 12'h000, 3'b001, 3'b000, {4'd0, 4'd0, 4'd4},    4'd5, 1'b1, 1'b1};
    tv[13] = '{1'b1, 3'b111, 3'b111, 12'hfff, 3'b000, 3'b000, 12'h000, 4'd4, 1'b1, 1'b1};
    tv[14] = '{1'b0, 3'b000, 3'b011, {4'd0, 4'd10, 4'd9},   3'b000, 3'b011, 12'h000, 4'd0, 1'b1, 1'b1};
    tv[15] = '{1'b0, 3'b111, 3'b000, 12'h000, 3'b011, 3'b000, {4'd0, 4'd10, 4'd9},   4'd2, 1'b1, 1'b1};
    tv[16] = '{1'b0, 3'b000, 3'b000, 12'h000, 3'b000, 3'b000, 12'h000, 4'd0, 1'b1, 1'b1};

    rst = 1'b1; flush = 1'b0; get_en = '0; put_en = '0; put_data = '0;
    @(posedge clk); @(posedge clk);

    for (int v = 0; v < 17; v++) begin
      @(negedge clk);
      rst = 1'b0; flush = tv[v].fl; get_en = tv[v].ge; put_en = tv[v].pe; put_data = tv[v].pd;
      #1;
      check($sformatf("v%0d get_grant", v), 32'(get_grant), 32'(tv[v].gg));
      check($sformatf("v%0d put_grant", v), 32'(put_grant), 32'(tv[v].pg));
      check($sformatf("v%0d get_data", v),  32'(get_data),  32'(tv[v].gd));
      check($sformatf("v%0d count", v),     32'(count),     32'(tv[v].cnt));
      check($sformatf("v%0d err_underflow", v), 32'(err_underflow), 32'(tv[v].eu));
      check($sformatf("v%0d err_overflow", v),  32'(err_overflow),  32'(tv[v].eo));
      @(posedge clk);
    end

    // Reset overrides flush and live requests; sticky flags clear, queue refills.
    @(negedge clk);
    rst = 1'b1; flush = 1'b1; get_en = 3'b111; put_en = 3'b111; put_data = 12'habc;
    #1;
    check("rst get_grant", 32'(get_grant), 32'd0);
    check("rst put_grant", 32'(put_grant), 32'd0);
    check("rst get_data",  32'(get_data),  32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; flush = 1'b0; get_en = '0; put_en = '0;
    #1;
    check("post-rst count", 32'(count), 32'd8);
    check("post-rst space", 32'(space), 32'd0);
    check("post-rst err_underflow", 32'(err_underflow), 32'd0);
    check("post-rst err_overflow",  32'(err_overflow),  32'd0);
    @(posedge clk);

    q.delete();
    for (int i = 0; i < DEPTH; i++) q.push_back(i);
    m_eu = 1'b0; m_eo = 1'b0;

    for (int cyc = 0; cyc < 2000; cyc++) begin
      logic          r, fl;
      logic [NP-1:0] ge, pe, egg, epg;
      logic [NP*WIDTH-1:0] pd, egd;
      int            pops, pushes, sp, ahead;
      int            pushed[$];

      r  = ($urandom_range(0, 199) == 0);
      fl = ($urandom_range(0, 31) == 0);
      ge = NP'($urandom);
      pe = NP'($urandom);
      pd = (NP*WIDTH)'($urandom);

      egg = '0; epg = '0; egd = '0; pops = 0; pushes = 0;
      pushed.delete();
      if (!r && !fl) begin
        ahead = 0;
        for (int i = 0; i < NP; i++) if (ge[i]) begin
          if (ahead < q.size()) begin
            egg[i] = 1'b1;
            egd[i*WIDTH +: WIDTH] = WIDTH'(q[pops]);
            pops++;
          end
          ahead++;
        end
        sp = DEPTH - q.size();
        ahead = 0;
        for (int i = 0; i < NP; i++) if (pe[i]) begin
          if (ahead < sp) begin
            epg[i] = 1'b1;
            pushed.push_back(int'(pd[i*WIDTH +: WIDTH]));
            pushes++;
          end
          ahead++;
        end
      end

      @(negedge clk);
      rst = r; flush = fl; get_en = ge; put_en = pe; put_data = pd;
      #1;
      check("rnd get_grant", 32'(get_grant), 32'(egg));
      check("rnd put_grant", 32'(put_grant), 32'(epg));
      check("rnd get_data",  32'(get_data),  32'(egd));
      check("rnd count",     32'(count),     32'(q.size()));
      check("rnd space",     32'(space),     32'(DEPTH - q.size()));
      check("rnd err_underflow", 32'(err_underflow), 32'(m_eu));
      check("rnd err_overflow",  32'(err_overflow),  32'(m_eo));
      @(posedge clk);

      if (r) begin
        q.delete();
        for (int i = 0; i < DEPTH; i++) q.push_back(i);
        m_eu = 1'b0; m_eo = 1'b0;
      end else if (fl) begin
        q.delete();
      end else begin
        if ((ge & ~egg) != '0) m_eu = 1'b1;
        if ((pe & ~epg) != '0) m_eo = 1'b1;
        for (int i = 0; i < pops; i++) void'(q.pop_front());
        foreach (pushed[i]) q.push_back(pushed[i]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mport_fifo.md
MPORT_FIFO -- requirements
Module: mport_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning the number of entries; legal values are powers of two, 2 or more.
REQ-002 SHALL have parameter WIDTH, default 6, meaning the entry width in bits.
REQ-003 SHALL have parameter NUM_PORTS, default 3, meaning the number of get lanes and the number of put lanes (1 or more).
REQ-004 SHALL have parameter INIT_FULL, default 1, meaning 1 = free-list mode (reset loads entry i with value i, full); 0 = empty at reset. INIT_FULL=1 requires WIDTH >= clog2(DEPTH).
REQ-005 SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit, meaning the reset; synchronous and active-high.
REQ-007 SHALL have port flush, input, 1 bit, meaning synchronous empty request.
REQ-008 SHALL have port get_en, input, NUM_PORTS bits, meaning per-lane pop requests.
REQ-009 SHALL have port get_grant, output, NUM_PORTS bits, meaning per-lane pop accepted this cycle.
REQ-010 SHALL have port get_data, output, NUM_PORTS x WIDTH, meaning the popped values, valid where get_grant=1.
REQ-011 SHALL have port put_en, input, NUM_PORTS bits, meaning per-lane push requests.
REQ-012 SHALL have port put_data, input, NUM_PORTS x WIDTH, meaning the push values.
REQ-013 SHALL have port put_grant, output, NUM_PORTS bits, meaning per-lane push accepted this cycle.
REQ-014 SHALL have port count, output, clog2(DEPTH)+1 bits, meaning registered occupancy.
REQ-015 SHALL have port space, output, clog2(DEPTH)+1 bits, meaning DEPTH-count, combinational.
REQ-016 SHALL have port err_underflow, output, 1 bit, meaning sticky flag: a get request was denied.
REQ-017 SHALL have port err_overflow, output, 1 bit, meaning sticky flag: a put request was denied.

Function
REQ-018 SHALL keep head/tail pointers of clog2(DEPTH) bits that wrap modulo DEPTH, plus a registered count, so full (count=DEPTH) and empty (count=0) are unambiguous.
REQ-019 SHALL grant get lane i iff get_en[i]=1 and (number of enabled gets on lanes below i) < count; grants are therefore in lane order, and partial acceptance is legal.
REQ-020 SHALL drive get_data[i] combinationally as mem[head + rank_i mod DEPTH], where rank_i = number of granted get lanes below i; get_data where get_grant=0 SHALL be 0.
REQ-021 SHALL grant put lane i iff put_en[i]=1 and (number of enabled puts on lanes below i) < space; space is taken at start of cycle, so entries freed by gets that same cycle are not reusable until the next cycle.
REQ-022 SHALL write put_data[i] of each granted put lane to mem[tail + rank_i mod DEPTH], where rank_i = number of granted put lanes below i; writes are visible to gets from the next cycle (no same-cycle bypass).
REQ-023 SHALL update on each edge: head += gets granted, tail += puts granted, count += puts granted - gets granted.
REQ-024 SHALL, when flush=1 and rst=0, force get_grant=0 and put_grant=0, and set head=tail=0, count=0, with mem unchanged; flush overrides all same-cycle requests.
REQ-025 SHALL set err_underflow/err_overflow one cycle after any denied get_en/put_en (flush cycles excluded); only rst clears them.
REQ-026 SHALL be purely registered at the count output; get_grant, put_grant, get_data, and space are combinational from state and inputs, with no combinational path from put_* to get_*.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, set head=0, tail=0, err_underflow=0, err_overflow=0, and set count=DEPTH (INIT_FULL=1, mem[i]=i) or count=0 (INIT_FULL=0, mem unchanged).
REQ-028 SHALL, while rst=1, hold all grants at 0 and get_data at 0; rst overrides flush and any in-flight requests, with no partial update.

Verification (DEPTH=8, WIDTH=4, NUM_PORTS=3, INIT_FULL=1)
REQ-029 SHALL cover: reset, then get_en=111 -> grants 111, data 0,1,2; next cycle count=5, head=3.
REQ-030 SHALL cover: sparse get_en=101 at head=3 -> grant 101, get_data[0]=3, get_data[2]=4, get_data[1]=0; count 5->3.
REQ-031 SHALL cover: count=2 with get_en=111 -> grant 011 (lanes 0,1), err_underflow=1 next cycle, count=0.
REQ-032 SHALL cover: count=8 with get_en=111 and put_en=111 (data A,B,C) -> put_grant=000, err_overflow=1, count=5; next cycle put_en=111 -> grant 111, count=8.
REQ-033 SHALL cover: wrap with head=6, count=8, get_en=111 -> data mem[6], mem[7], mem[0]; head=1.
REQ-034 SHALL cover: flush=1 with get_en=111 and put_en=111 at count=4 -> all grants 0; next cycle count=0; then put 2 -> count=2, and the next get returns those 2 values in order.
